risc16_mc_control: RTL

- Multi-cycle control sequencer for the RiSC-16 processor. It drives the shared ALU (funct, operand select) and sequences fetch, decode, execute, memory and writeback.
- Issues strobes to the IR, PC, register file and a single shared instruction/data memory port.
- Consumes the ALU zero flag for BEQ resolution.
- One instruction in flight at a time; no pipelining.

---
 rtl/risc16_mc_control.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/risc16_mc_control.sv
// Multi-cycle control sequencer for the RiSC-16 processor.
// It steps through fetch, decode, execute, memory and writeback over one shared memory port.
module risc16_mc_control #(
    parameter int ALU_FUNCT_LEN = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2:0]               opcode,
    input  logic                     imm_nz,
    input  logic                     alu_zero,
    input  logic                     mem_ready,
    output logic                     mem_req,
    output logic                     mem_we,
    output logic                     ir_we,
    output logic                     pc_we,
    output logic [1:0]               pc_src,
    output logic [ALU_FUNCT_LEN-1:0] alu_funct,
    output logic                     alu_srcb_sel,
    output logic                     rf_we,
    output logic [1:0]               rf_wsel,
    output logic                     halted
);

    // ALU function encodings, shared with the datapath ALU
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_ADD   = ALU_FUNCT_LEN'(0);
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_NAND  = ALU_FUNCT_LEN'(1);
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_PASSA = ALU_FUNCT_LEN'(2);
    localparam logic [ALU_FUNCT_LEN-1:0] ALU_SUB   = ALU_FUNCT_LEN'(3);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_ADDI = 3'b001;
    localparam logic [2:0] OP_NAND = 3'b010;
    localparam logic [2:0] OP_LUI  = 3'b011;
    localparam logic [2:0] OP_SW   = 3'b100;
    localparam logic [2:0] OP_LW   = 3'b101;
    localparam logic [2:0] OP_BEQ  = 3'b110;
    localparam logic [2:0] OP_JALR = 3'b111;

    localparam logic [2:0] S_RESET  = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_MEM    = 3'd4;
    localparam logic [2:0] S_WB     = 3'd5;
    localparam logic [2:0] S_HALT   = 3'd6;

    logic [2:0] state;
    logic [2:0] state_next;
    logic [2:0] op_q;

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_RESET;
            op_q  <= 3'b000;
        end else begin
            state <= state_next;
            if (state == S_DECODE) begin
                op_q <= opcode;
            end
        end
    end

    // NOTE: every output and state_next gets a default first, so no path leaves them unassigned (no latches).
    always_comb begin
        state_next   = state;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_src       = 2'd0;
        alu_funct    = ALU_ADD;
        alu_srcb_sel = 1'b0;
        rf_we        = 1'b0;
        rf_wsel      = 2'd0;
        halted       = 1'b0;

        case (state)
            S_RESET: state_next = S_FETCH;

            S_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we      = 1'b1;
                    pc_we      = 1'b1;
                    state_next = S_DECODE;
                end
            end

            S_DECODE: begin
                if (opcode == OP_LUI) begin
                    state_next = S_WB;
                end else if (opcode == OP_JALR && imm_nz) begin
                    state_next = S_HALT;
                end else begin
                    state_next = S_EXEC;
                end
            end

            S_EXEC: begin
                state_next = S_WB;
                case (op_q)
                    OP_ADDI: alu_srcb_sel = 1'b1;
                    OP_NAND: alu_funct = ALU_NAND;
                    OP_SW, OP_LW: begin
                        alu_srcb_sel = 1'b1;
                        state_next   = S_MEM;
                    end
                    OP_BEQ: begin
                        alu_funct  = ALU_SUB;
                        state_next = S_FETCH;
                        if (alu_zero) begin
                            pc_we  = 1'b1;
                            pc_src = 2'd1;
                        end
                    end
                    OP_JALR: begin
                        // Register file latches the already-incremented PC in the same edge the PC reloads.
                        alu_funct  = ALU_PASSA;
                        pc_we      = 1'b1;
                        pc_src     = 2'd2;
                        rf_we      = 1'b1;
                        rf_wsel    = 2'd3;
                        state_next = S_FETCH;
                    end
                    default: ;
                endcase
            end

            S_MEM: begin
                mem_req      = 1'b1;
                mem_we       = (op_q == OP_SW);
                alu_srcb_sel = 1'b1;
                if (mem_ready) begin
                    state_next = (op_q == OP_LW) ? S_WB : S_FETCH;
                end
            end

            S_WB: begin
                rf_we      = 1'b1;
                state_next = S_FETCH;
                case (op_q)
                    OP_ADDI: alu_srcb_sel = 1'b1;
                    OP_NAND: alu_funct = ALU_NAND;
                    OP_LW: begin
                        alu_srcb_sel = 1'b1;
                        rf_wsel      = 2'd1;
                    end
                    OP_LUI:  rf_wsel = 2'd2;
                    default: ;
                endcase
            end

            S_HALT: halted = 1'b1;

            default: state_next = S_RESET;
        endcase
    end

endmodule
